oh_to_idx_pipe: RTL

Registered one-hot to index decoder with a valid/ready handshake; the inverse of the team's combinational index-to-one-hot decoder. Converts a one-hot select vector, such as an arbiter grant or thread/lane select, back to a binary index. Flags zero-hot and multi-hot inputs. A two-entry skid buffer keeps `in_ready` registered, so the block can sit between pipeline stages at full throughput.

---
 rtl/oh_to_idx_pipe_pkg.sv | 12 +
 rtl/oh_to_idx_pipe_if.sv | 28 ++
 rtl/oh_to_idx_pipe_oh_to_idx.sv | 25 ++
 rtl/oh_to_idx_pipe.sv | 110 +++++++++++
 4 files changed

// File: rtl/oh_to_idx_pipe_pkg.sv
// Shared definitions for the one-hot to index pipe: FSM encodings and defaults.
package oh_to_idx_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

    localparam int ERR_CNT_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/oh_to_idx_pipe_if.sv
// Handshake bundle for oh_to_idx_pipe: input side, output side and error counter.
interface oh_to_idx_pipe_if
    import oh_to_idx_pipe_pkg::*;
#(
    parameter int OH_WIDTH      = 4,
    parameter int IDX_WIDTH     = 2,
    parameter int ERR_CNT_WIDTH = ERR_CNT_WIDTH_DEFAULT
);
    logic                     in_valid;
    logic                     in_ready;
    logic [OH_WIDTH-1:0]      in_one_hot;
    logic                     out_valid;
    logic                     out_ready;
    logic [IDX_WIDTH-1:0]     out_idx;
    logic                     out_zero;
    logic                     out_multi;
    logic [ERR_CNT_WIDTH-1:0] err_cnt;

    modport master (
        output in_valid, in_one_hot, out_ready,
        input  in_ready, out_valid, out_idx, out_zero, out_multi, err_cnt
    );

    modport slave (
        input  in_valid, in_one_hot, out_ready,
        output in_ready, out_valid, out_idx, out_zero, out_multi, err_cnt
    );
endinterface

// File: rtl/oh_to_idx_pipe_oh_to_idx.sv
// Combinational lowest-set-bit encoder with zero-hot and multi-hot flags.
module oh_to_idx #(
    parameter int OH_WIDTH  = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [OH_WIDTH-1:0]  one_hot,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 zero,
    output logic                 multi
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = OH_WIDTH - 1; i >= 0; i--) begin
            if (one_hot[i]) begin
                idx = IDX_WIDTH'(i);
            end
        end
    end

    assign zero  = (one_hot == '0);
    assign multi = |(one_hot & (one_hot - OH_WIDTH'(1)));

endmodule

// File: rtl/oh_to_idx_pipe.sv
// Registered one-hot to index decoder with a two-entry skid buffer.
// Optional multi-hot error counter enabled by OH_TO_IDX_PIPE_ERR_CNT_EN.
module oh_to_idx_pipe
    import oh_to_idx_pipe_pkg::*;
#(
    parameter int OH_WIDTH      = 4,
    parameter int IDX_WIDTH     = 2,
    parameter int ERR_CNT_WIDTH = ERR_CNT_WIDTH_DEFAULT
) (
    input logic              clk,
    input logic              rst_n,
    oh_to_idx_pipe_if.slave  bus
);

    typedef struct packed {
        logic [IDX_WIDTH-1:0] idx;
        logic                 zero;
        logic                 multi;
    } entry_t;

    pipe_state_t state;
    entry_t      main_q;
    entry_t      skid_q;
    entry_t      dec;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        accept;
    logic        deliver;

    oh_to_idx #(
        .OH_WIDTH  (OH_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_dec (
        .one_hot (bus.in_one_hot),
        .idx     (dec.idx),
        .zero    (dec.zero),
        .multi   (dec.multi)
    );

    assign accept  = bus.in_valid && in_ready_q;
    assign deliver = out_valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q      <= dec;
                        out_valid_q <= 1'b1;
                        state       <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !deliver) begin
                        skid_q     <= dec;
                        in_ready_q <= 1'b0;
                        state      <= ST_TWO;
                    end else if (!accept && deliver) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_EMPTY;
                    end else if (accept && deliver) begin
                        main_q <= dec;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the drain path exists.
                    if (deliver) begin
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                        state      <= ST_ONE;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = main_q.idx;
    assign bus.out_zero  = main_q.zero;
    assign bus.out_multi = main_q.multi;

`ifdef OH_TO_IDX_PIPE_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (accept && dec.multi && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = {ERR_CNT_WIDTH{1'b0}};
`endif

endmodule
